// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - fills instruction memory from a byte stream and holds the core in reset until done
// Optional trailing XOR checksum word: define INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              inst_mem_rstn,
  output logic              inst_mem_wr_en,
  output logic [ADDR_W-1:0] inst_mem_wr_addr,
  output logic [31:0]       inst_mem_wr_data,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, CHECK, DONE, ERROR} state_t;
  logic [31:0] xor_acc;
`else
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, DONE, ERROR} state_t;
`endif

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [ADDR_W:0]  word_idx;
  logic [ADDR_W:0]  cnt_q;
  logic [TMO_W-1:0] tmo;
  logic             accept;

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      s_ready          <= 1'b0;
      inst_mem_rstn    <= 1'b0;
      inst_mem_wr_en   <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_data <= '0;
      cpu_rstn         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      byte_cnt         <= '0;
      word_buf         <= '0;
      word_idx         <= '0;
      cnt_q            <= '0;
      tmo              <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_acc          <= '0;
`endif
    end else begin
      inst_mem_wr_en <= 1'b0;
      inst_mem_rstn  <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rstn <= 1'b0;
            byte_cnt <= '0;
            word_idx <= '0;
            tmo      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
            if (word_cnt == '0 || word_cnt > MAX_CNT) begin
              err   <= 1'b1;
              state <= ERROR;
            end else begin
              cnt_q         <= word_cnt;
              busy          <= 1'b1;
              inst_mem_rstn <= 1'b0;
              state         <= CLEAR;
            end
          end
        end
        CLEAR: begin
          s_ready <= 1'b1;
          state   <= LOAD;
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_acc  <= xor_acc ^ inst_mem_wr_data;
`endif
          s_ready  <= 1'b1;
          if (word_idx == cnt_q - 1'b1) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state    <= CHECK;
`else
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_rstn <= 1'b1;
            state    <= DONE;
`endif
          end else begin
            state <= LOAD;
          end
        end
        default: begin
          // LOAD and CHECK: gather little-endian bytes, shifting each new byte in from the top
          if (accept) begin
            tmo      <= '0;
            byte_cnt <= byte_cnt + 1'b1;
            word_buf <= {s_data, word_buf[23:8]};
            if (byte_cnt == 2'd3) begin
              s_ready <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
              if (state == CHECK) begin
                busy <= 1'b0;
                if ({s_data, word_buf} == xor_acc) begin
                  done     <= 1'b1;
                  cpu_rstn <= 1'b1;
                  state    <= DONE;
                end else begin
                  err   <= 1'b1;
                  state <= ERROR;
                end
              end else
`endif
              begin
                inst_mem_wr_en   <= 1'b1;
                inst_mem_wr_addr <= word_idx[ADDR_W-1:0];
                inst_mem_wr_data <= {s_data, word_buf};
                state            <= WRITE;
              end
            end
          end else if (tmo == TMO_LAST) begin
            // partial word is dropped; nothing more is written
            s_ready <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ERROR;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
